aout_cmd_scheduler: RTL

- Shares one Moore output-control unit between NREQ requesters. The unit has a 2-bit command input: 01/10/11 selects the clear/toggle/set mode, and 00 applies the selected mode to its output bit.
- The scheduler arbitrates round-robin, turns each granted operation into the unit's select-then-apply sequence, and acks the requester.
- It parks the unit between commands so no unintended apply occurs.
- It keeps a shadow copy of the unit's output bit for status reads and verification.

---
 rtl/aout_cmd_scheduler.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/aout_cmd_scheduler.sv
// aout_cmd_scheduler
// Round-robin scheduler sharing one Moore output-control unit between NREQ
// requesters. Each granted opcode is turned into a select cycle followed by a
// single apply cycle (ain=00). The unit is parked on 01 (clear mode selected,
// nothing applied) whenever it is not being commanded. A shadow copy of the
// unit's output bit is kept for status reads.
module aout_cmd_scheduler #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2,
  parameter int GAP   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op,
  output logic [NREQ-1:0]   ack,
  output logic [1:0]        ain_out,
  output logic              busy,
  output logic [IDX_W-1:0]  grant_id,
  output logic              shadow_aout,
  output logic              init_done
);

  typedef enum logic [2:0] {
    ST_INIT_SEL   = 3'd0,
    ST_INIT_APPLY = 3'd1,
    ST_IDLE       = 3'd2,
    ST_SEL        = 3'd3,
    ST_APPLY      = 3'd4,
    ST_DONE       = 3'd5,
    ST_GAP        = 3'd6
  } state_t;

  localparam logic [1:0] CMD_APPLY  = 2'b00;
  localparam logic [1:0] CMD_CLEAR  = 2'b01;
  localparam logic [1:0] CMD_TOGGLE = 2'b10;
  localparam logic [1:0] CMD_SET    = 2'b11;

  // Park counter runs 0..GAP-2 while in ST_GAP (DONE is the first park cycle).
  localparam int GCW = (GAP > 2) ? $clog2(GAP) : 1;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [IDX_W-1:0]  last_r;
  logic [1:0]        op_r;
  logic [GCW-1:0]    gap_cnt_r;

  logic              found_s;
  logic [IDX_W-1:0]  pick_s;
  logic [IDX_W-1:0]  cand_s;
  logic [2*NREQ-1:0] op_shift_s;
  logic [1:0]        op_nxt_s;
  logic [IDX_W-1:0]  grant_nxt_s;
  logic [1:0]        ain_nxt_s;
  logic [NREQ-1:0]   ack_nxt_s;
  logic              busy_nxt_s;
  logic              shadow_nxt_s;
  logic              init_done_nxt_s;

  // Effect of an applied command on the unit's output bit.
  function automatic logic apply_cmd(input logic [1:0] cmd, input logic cur);
    case (cmd)
      CMD_CLEAR:  apply_cmd = 1'b0;
      CMD_TOGGLE: apply_cmd = ~cur;
      CMD_SET:    apply_cmd = 1'b1;
      default:    apply_cmd = cur;
    endcase
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Round-robin search starting one past the last grant, wrapping around.
  always_comb begin
    found_s = 1'b0;
    pick_s  = last_r;
    cand_s  = last_r;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IDX_W'((int'(last_r) + k) % NREQ);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign op_shift_s = op >> {pick_s, 1'b0};

  // Next-state logic, opcode capture and grant selection.
  always_comb begin
    state_nxt_s = state_r;
    op_nxt_s    = op_r;
    grant_nxt_s = grant_id;
    case (state_r)
      ST_INIT_SEL:   state_nxt_s = ST_INIT_APPLY;
      ST_INIT_APPLY: state_nxt_s = ST_IDLE;
      ST_IDLE: begin
        if (found_s) begin
          state_nxt_s = ST_SEL;
          grant_nxt_s = pick_s;
          op_nxt_s    = op_shift_s[1:0];
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEL: begin
        if (op_r == CMD_APPLY) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_APPLY;
        end
      end
      ST_APPLY: state_nxt_s = ST_DONE;
      ST_DONE: begin
        if (GAP <= 1) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      ST_GAP: begin
        if (int'(gap_cnt_r) >= GAP - 2) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: state_nxt_s = ST_INIT_SEL;
    endcase
  end

  // Output decode for the upcoming state, so every output leaves a flop.
  always_comb begin
    ain_nxt_s       = CMD_CLEAR;
    ack_nxt_s       = '0;
    busy_nxt_s      = 1'b1;
    shadow_nxt_s    = shadow_aout;
    init_done_nxt_s = init_done;
    case (state_nxt_s)
      ST_INIT_SEL:   ain_nxt_s = CMD_CLEAR;
      ST_INIT_APPLY: ain_nxt_s = CMD_APPLY;
      ST_IDLE: begin
        ain_nxt_s  = CMD_CLEAR;
        busy_nxt_s = 1'b0;
      end
      ST_SEL:        ain_nxt_s = op_nxt_s;
      ST_APPLY:      ain_nxt_s = CMD_APPLY;
      ST_DONE: begin
        ain_nxt_s = CMD_CLEAR;
        ack_nxt_s = onehot(grant_nxt_s);
      end
      ST_GAP:        ain_nxt_s = CMD_CLEAR;
      default:       ain_nxt_s = CMD_CLEAR;
    endcase
    if (state_r == ST_APPLY) begin
      shadow_nxt_s = apply_cmd(op_r, shadow_aout);
    end else if (state_r == ST_INIT_APPLY) begin
      shadow_nxt_s    = 1'b0;
      init_done_nxt_s = 1'b1;
    end else begin
      shadow_nxt_s = shadow_aout;
    end
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_INIT_SEL;
      last_r      <= IDX_W'(NREQ - 1);
      op_r        <= 2'b00;
      gap_cnt_r   <= '0;
      ack         <= '0;
      ain_out     <= CMD_CLEAR;
      busy        <= 1'b1;
      grant_id    <= '0;
      shadow_aout <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      op_r        <= op_nxt_s;
      grant_id    <= grant_nxt_s;
      ack         <= ack_nxt_s;
      ain_out     <= ain_nxt_s;
      busy        <= busy_nxt_s;
      shadow_aout <= shadow_nxt_s;
      init_done   <= init_done_nxt_s;
      if (state_r == ST_IDLE && found_s) begin
        last_r <= pick_s;
      end else begin
        last_r <= last_r;
      end
      if (state_r == ST_GAP) begin
        gap_cnt_r <= gap_cnt_r + GCW'(1);
      end else begin
        gap_cnt_r <= '0;
      end
    end
  end

endmodule
